divider_result_bcd: RTL and testbench
=====================================

# divider_result_bcd

Downstream consumer of the 8-bit divider's result handshake. On `Done` it captures `Quotient` and `Remainder` and converts both to 3-digit BCD with an iterative shift-add-3 (double-dabble) sequence. It registers the digits for the seven-segment display mux and returns a one-cycle `Ack` so the divider goes back to its initial state. Conversion is sequential: one bit per clock, both operands in parallel.

## Interface
- `WIDTH`, 8: binary operand width. The BCD logic is sized for 8 bits; only 8 is supported.
- `DIGITS`, 3: BCD digits per operand.
- `Clk`  in  1: the single clock; all logic is on the rising edge.
- `Resetn`  in  1: synchronous, active-low reset, sampled on the rising edge of `Clk`.
- `Done`  in  1: divider result-valid, held high until it is acknowledged.
- `Quotient`  in  8: divider quotient, stable while `Done` is high.
- `Remainder`  in  8: divider remainder, stable while `Done` is high.
- `Ack`  out  1: one-cycle acknowledge pulse to the divider.
- `QBcd`  out  12: quotient BCD as {hundreds, tens, ones}.
- `RBcd`  out  12: remainder BCD, same layout.
- `Valid`  out  1: high once a conversion has completed since reset.
- `Busy`  out  1: high in CAPTURE-to-ACK states (CONV, ACK).
- `Blank`  out  6: per-digit blank flags as {Q_h, Q_t, Q_o, R_h, R_t, R_o}.

## Operation
- One-hot FSM with states IDLE, CONV, ACK and WAITLOW.
- **IDLE:** when `Done`=1 at an edge:
  - load the shift registers with `Quotient` and `Remainder`;
  - clear both 12-bit BCD accumulators;
  - set `cnt`=0 and go to CONV.
- **CONV:** on each edge, for each operand:
  - every BCD nibble ≥5 gets +3;
  - then {bcd, shift} shifts left by 1, MSB of the shift register entering bcd[0];
  - `cnt` increments.
- **Leaving CONV:** on the edge where `cnt`==7, the post-shift BCD values load into `QBcd`/`RBcd`, `Valid` is set, and the state goes to ACK.
- **ACK:** `Ack`=1 for exactly this one cycle; the next edge goes to WAITLOW unconditionally.
- **WAITLOW:** stay while `Done`=1 and go to IDLE when `Done`=0. This prevents recapturing the same result if the divider's `Done` falls late.
- **Output stability:**
  - `QBcd`/`RBcd`/`Blank` change only on the edge leaving CONV;
  - they hold their previous result during a new conversion.
- **Arithmetic:** inputs are unsigned 0..255. Nibbles never exceed 9 after the final shift, and the hundreds digit is ≤2.
- **Reset:** `Resetn`=0 at any edge, including mid-CONV, forces:
  - state IDLE, `cnt`=0;
  - `Ack`=0, `Valid`=0, `Busy`=0;
  - `QBcd`=`RBcd`=0, `Blank`=0.

  A conversion interrupted by reset is discarded and produces no `Ack`.
- **Done in other states:** ignored outside IDLE and WAITLOW.

## Timing
- Capture edge E0 (IDLE, `Done`=1). CONV spans edges E1..E8, and the results update at E8.
- `Ack` is high in the cycle between E8 and E9. The divider leaves its done state at E9, so `Done` is low from E9.
- Latency from `Done` sampled to `Ack` high: 8 cycles. Minimum throughput: one result per 11 cycles (IDLE, 8×CONV, ACK, WAITLOW).
- `Ack`, `Busy` and `Valid` are registered decodes, with no combinational path from `Done`.

## Configuration
- `BCD_LEADING_ZERO_BLANK_EN` defined:
  - `Blank` flags a hundreds digit that is 0;
  - it flags a tens digit that is 0 when hundreds is also 0;
  - ones is never blanked;
  - flags are registered alongside `QBcd`/`RBcd`.
- Macro undefined: `Blank` is tied to 6'b0 and the blanking logic is absent.

## Structure
- Package `divider_pkg`:
  - state localparams (4-bit one-hot IDLE/CONV/ACK/WAITLOW);
  - `WIDTH`, `DIGITS`;
  - the BCD nibble add-3 threshold 5.
- Sub-module `bcd_dabble_step`: purely combinational. It performs one add-3 on each nibble and one left shift for a 12-bit BCD + 8-bit shift pair, and is instantiated twice (quotient, remainder).

## Test plan
- **Maximum values:** `Done` with Q=255, R=0 → `QBcd`=12'h255, `RBcd`=12'h000, `Ack` is a single pulse 8 cycles after capture, `Valid`=1.
- **Mid-range values:** Q=100, R=7 → 12'h100, 12'h007. With the macro: `Blank`=6'b000_110. Without it: `Blank`=0.
- **Done held high:** `Done` stays high 5 cycles past `Ack` → exactly one `Ack`, FSM sits in WAITLOW, no second capture.
- **Reset mid-conversion:** Q=199 then `Resetn`=0 at the 4th CONV edge → every output 0, no `Ack`. A later `Done` with Q=42, R=3 yields 12'h042, 12'h003.
- **Back-to-back results:** Q=9 then Q=10 → outputs hold 12'h009 throughout the second CONV and switch to 12'h010 on its completion edge.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared constants, FSM state encoding and BCD helpers for the divider result
// BCD converter.
package divider_pkg;

    localparam int WIDTH  = 8;
    localparam int DIGITS = 3;
    localparam int BCD_W  = 4 * DIGITS;

    localparam logic [3:0] BCD_ADD3_THRESH = 4'd5;

    // One-hot encoding, 4 bits.
    typedef enum logic [3:0] {
        ST_IDLE    = 4'b0001,
        ST_CONV    = 4'b0010,
        ST_ACK     = 4'b0100,
        ST_WAITLOW = 4'b1000
    } state_t;

    function automatic logic [3:0] bcd_add3(input logic [3:0] nib);
        return (nib >= BCD_ADD3_THRESH) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add-3 on every BCD nibble, then shift
// {bcd, shift} left by one bit.
module bcd_dabble_step
    import divider_pkg::*;
(
    input  logic [BCD_W-1:0] i_bcd,
    input  logic [WIDTH-1:0] i_shift,
    output logic [BCD_W-1:0] o_bcd,
    output logic [WIDTH-1:0] o_shift
);

    logic [BCD_W-1:0] w_adj;

    assign w_adj   = {bcd_add3(i_bcd[11:8]), bcd_add3(i_bcd[7:4]), bcd_add3(i_bcd[3:0])};
    assign o_bcd   = {w_adj[BCD_W-2:0], i_shift[WIDTH-1]};
    assign o_shift = {i_shift[WIDTH-2:0], 1'b0};

endmodule

// File: rtl/divider_result_bcd.sv
// Captures the divider quotient/remainder on Done, converts both to 3-digit BCD
// one bit per clock and acknowledges. Optional: BCD_LEADING_ZERO_BLANK_EN.
module divider_result_bcd
    import divider_pkg::*;
(
    input  logic             Clk,
    input  logic             Resetn,
    input  logic             Done,
    input  logic [WIDTH-1:0] Quotient,
    input  logic [WIDTH-1:0] Remainder,
    output logic             Ack,
    output logic [BCD_W-1:0] QBcd,
    output logic [BCD_W-1:0] RBcd,
    output logic             Valid,
    output logic             Busy,
    output logic [5:0]       Blank
);

    state_t r_state;
    state_t w_next;

    logic [2:0]       r_cnt;
    logic [WIDTH-1:0] r_q_sh,  r_r_sh;
    logic [BCD_W-1:0] r_q_acc, r_r_acc;
    logic [BCD_W-1:0] r_q_bcd, r_r_bcd;
    logic             r_valid;

    logic [WIDTH-1:0] w_q_sh,  w_r_sh;
    logic [BCD_W-1:0] w_q_bcd, w_r_bcd;

    bcd_dabble_step u_step_q (
        .i_bcd   (r_q_acc),
        .i_shift (r_q_sh),
        .o_bcd   (w_q_bcd),
        .o_shift (w_q_sh)
    );

    bcd_dabble_step u_step_r (
        .i_bcd   (r_r_acc),
        .i_shift (r_r_sh),
        .o_bcd   (w_r_bcd),
        .o_shift (w_r_sh)
    );

    always_ff @(posedge Clk) begin
        if (!Resetn) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (Done) w_next = ST_CONV;
            ST_CONV:    if (r_cnt == 3'd7) w_next = ST_ACK;
            ST_ACK:     w_next = ST_WAITLOW;
            // Holding here until Done drops stops a late Done from being recaptured.
            ST_WAITLOW: if (!Done) w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Resetn) begin
            r_cnt   <= '0;
            r_q_sh  <= '0;
            r_r_sh  <= '0;
            r_q_acc <= '0;
            r_r_acc <= '0;
            r_q_bcd <= '0;
            r_r_bcd <= '0;
            r_valid <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && Done) begin
                r_q_sh  <= Quotient;
                r_r_sh  <= Remainder;
                r_q_acc <= '0;
                r_r_acc <= '0;
                r_cnt   <= '0;
            end else if (r_state == ST_CONV) begin
                r_q_sh  <= w_q_sh;
                r_r_sh  <= w_r_sh;
                r_q_acc <= w_q_bcd;
                r_r_acc <= w_r_bcd;
                r_cnt   <= r_cnt + 3'd1;
                if (r_cnt == 3'd7) begin
                    r_q_bcd <= w_q_bcd;
                    r_r_bcd <= w_r_bcd;
                    r_valid <= 1'b1;
                end
            end
        end
    end

`ifdef BCD_LEADING_ZERO_BLANK_EN
    function automatic logic [2:0] lead_blank(input logic [BCD_W-1:0] b);
        return {b[11:8] == 4'd0, b[11:4] == 8'd0, 1'b0};
    endfunction

    logic [5:0] r_blank;

    always_ff @(posedge Clk) begin
        if (!Resetn)
            r_blank <= '0;
        else if (r_state == ST_CONV && r_cnt == 3'd7)
            r_blank <= {lead_blank(w_q_bcd), lead_blank(w_r_bcd)};
    end

    assign Blank = r_blank;
`else
    assign Blank = 6'b0;
`endif

    assign Ack   = (r_state == ST_ACK);
    assign Busy  = (r_state == ST_CONV) || (r_state == ST_ACK);
    assign Valid = r_valid;
    assign QBcd  = r_q_bcd;
    assign RBcd  = r_r_bcd;

endmodule

// File: tb/tb_divider_result_bcd.sv
// Directed scoreboard bench for divider_result_bcd; honours BCD_LEADING_ZERO_BLANK_EN.
module tb_divider_result_bcd;

    logic        Clk = 1'b0;
    logic        Resetn = 1'b0;
    logic        Done = 1'b0;
    logic [7:0]  Quotient = '0;
    logic [7:0]  Remainder = '0;
    logic        Ack, Valid, Busy;
    logic [11:0] QBcd, RBcd;
    logic [5:0]  Blank;

    divider_result_bcd dut (
        .Clk       (Clk),
        .Resetn    (Resetn),
        .Done      (Done),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .Ack       (Ack),
        .QBcd      (QBcd),
        .RBcd      (RBcd),
        .Valid     (Valid),
        .Busy      (Busy),
        .Blank     (Blank)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [11:0] q;
        logic [11:0] r;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    logic [11:0] prev_q = '0;
    logic [11:0] prev_r = '0;

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [2:0] blank3(input logic [11:0] b);
`ifdef BCD_LEADING_ZERO_BLANK_EN
        return {b[11:8] == 4'd0, b[11:4] == 8'd0, 1'b0};
`else
        return 3'b000;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ack"},   32'(Ack),   0);
        chk({tag, "_busy"},  32'(Busy),  0);
        chk({tag, "_valid"}, 32'(Valid), 0);
        chk({tag, "_qbcd"},  32'(QBcd),  0);
        chk({tag, "_rbcd"},  32'(RBcd),  0);
        chk({tag, "_blank"}, 32'(Blank), 0);
    endtask

    // Drive one result, wait for Ack, compare against scoreboard, then keep Done
    // high for 'hold' extra cycles past the acknowledge.
    task automatic xfer(input logic [7:0] q, input logic [7:0] r, input int hold);
        int   cyc;
        exp_t e;
        @(negedge Clk);
        Quotient = q;
        Remainder = r;
        Done = 1'b1;
        sb.push_back('{q: to_bcd(int'(q)), r: to_bcd(int'(r))});
        cyc = 0;
        do begin
            @(negedge Clk);
            cyc++;
            if (!Ack) begin
                chk("hold_qbcd", 32'(QBcd), 32'(prev_q));
                chk("hold_rbcd", 32'(RBcd), 32'(prev_r));
            end
        end while (!Ack && cyc < 30);
        chk("ack_latency", cyc, 9);
        chk("sb_nonempty", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) e = sb.pop_front();
        else e = '{q: 12'hfff, r: 12'hfff};
        chk("qbcd",  32'(QBcd),  32'(e.q));
        chk("rbcd",  32'(RBcd),  32'(e.r));
        chk("blank", 32'(Blank), 32'({blank3(e.q), blank3(e.r)}));
        chk("valid", 32'(Valid), 1);
        chk("busy_ack", 32'(Busy), 1);
        prev_q = e.q;
        prev_r = e.r;
        if (hold == 0) Done = 1'b0;
        @(negedge Clk);
        chk("ack_single", 32'(Ack), 0);
        chk("busy_after", 32'(Busy), 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge Clk);
            chk("waitlow_ack",  32'(Ack),  0);
            chk("waitlow_busy", 32'(Busy), 0);
            chk("waitlow_qbcd", 32'(QBcd), 32'(prev_q));
        end
        if (hold != 0) begin
            Done = 1'b0;
            @(negedge Clk);
        end
    endtask

    initial begin
        int acks;

        repeat (3) @(negedge Clk);
        check_zero("reset");
        Resetn = 1'b1;

        xfer(8'd255, 8'd0, 0);
        xfer(8'd100, 8'd7, 0);
        xfer(8'd37,  8'd255, 5);

        // Reset asserted so it is sampled on the 4th CONV edge.
        @(negedge Clk);
        Quotient = 8'd199;
        Remainder = 8'd58;
        Done = 1'b1;
        repeat (4) @(negedge Clk);
        Resetn = 1'b0;
        Done = 1'b0;
        @(negedge Clk);
        check_zero("midreset");
        Resetn = 1'b1;
        prev_q = '0;
        prev_r = '0;
        acks = 0;
        repeat (12) begin
            @(negedge Clk);
            if (Ack) acks++;
        end
        chk("midreset_no_ack", acks, 0);
        chk("midreset_valid", 32'(Valid), 0);

        xfer(8'd42, 8'd3, 0);
        xfer(8'd9,  8'd0, 0);
        xfer(8'd10, 8'd1, 0);

        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
